// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor: one full-subtractor cell and a registered borrow,
// LSB first, with a start/busy/done handshake. Diff = A - B - Bin, Bout = unsigned underflow.
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Diff,
  output logic             Bout
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] sa, sb, res;
  logic             borrow;
  logic [CNT_W-1:0] count;
  logic             load, step, last;
  logic             d, br_next;

  // Full-subtractor cell: returns {borrow_out, difference}.
  function automatic logic [1:0] full_sub(input logic a, input logic b, input logic br);
    full_sub = {(~a & b) | (~(a ^ b) & br), a ^ b ^ br};
  endfunction

  assign {br_next, d} = full_sub(sa[0], sb[0], borrow);
  assign last         = (count == CNT_W'(WIDTH - 1));
  assign busy         = (state == SHIFT);
  assign done         = (state == DONE);

  always_comb begin
    state_next = state;
    load       = 1'b0;
    step       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load       = 1'b1;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        step = 1'b1;
        if (last) state_next = DONE;
      end
      DONE: begin
        // Back-to-back: a start seen in DONE is accepted just like in IDLE.
        if (start) begin
          load       = 1'b1;
          state_next = SHIFT;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      sa     <= '0;
      sb     <= '0;
      res    <= '0;
      borrow <= 1'b0;
      count  <= '0;
      Diff   <= '0;
      Bout   <= 1'b0;
    end else begin
      state <= state_next;
      if (load) begin
        sa     <= A;
        sb     <= B;
        borrow <= Bin;
        count  <= '0;
      end else if (step) begin
        sa     <= sa >> 1;
        sb     <= sb >> 1;
        borrow <= br_next;
        res    <= {d, res[WIDTH-1:1]};
        count  <= count + CNT_W'(1);
        // Outputs move only when the final bit lands, so they hold between results.
        if (last) begin
          Diff <= {d, res[WIDTH-1:1]};
          Bout <= br_next;
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and randomized checks of serial_subtractor (WIDTH=4): reset state, handshake
// timing, borrow corner cases, start held through SHIFT, mid-op reset abort.
module tb_serial_subtractor;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         reset, start, Bin;
  logic [W-1:0] A, B;
  logic         busy, done, Bout;
  logic [W-1:0] Diff;

  int n_cmp = 0;
  int n_bad = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .A(A), .B(B), .Bin(Bin),
    .busy(busy), .done(done), .Diff(Diff), .Bout(Bout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Issue one op from IDLE, then wait (bounded) for done and check result and busy length.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi,
                        input logic [W:0] exp);
    int nb;
    @(negedge clk);
    A = a; B = b; Bin = bi; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    A = ~a; B = ~b; Bin = ~bi;
    nb = 0;
    while (!done && nb < 20) begin
      if (busy) nb++;
      @(negedge clk);
    end
    chk("done_seen", done, 1'b1);
    chk("busy_cycles", nb, W);
    chk("diff", Diff, exp[W-1:0]);
    chk("bout", Bout, exp[W]);
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    logic         rbi;
    int           n;

    reset = 1'b1; start = 1'b0; A = '0; B = '0; Bin = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_diff", Diff, 4'h0);
      chk("rst_bout", Bout, 1'b0);
    end

    // Directed vectors
    run_op(4'd9, 4'd3, 1'b0, 5'h06);
    @(negedge clk);
    chk("done_pulse_1cyc", done, 1'b0);
    chk("diff_held", Diff, 4'h6);
    run_op(4'd3, 4'd9, 1'b0, 5'h1A);
    run_op(4'd0, 4'd0, 1'b1, 5'h1F);
    run_op(4'hF, 4'hF, 1'b0, 5'h00);
    run_op(4'h0, 4'hF, 1'b0, 5'h11);
    run_op(4'hF, 4'h0, 1'b1, 5'h0E);
    run_op(4'h8, 4'h7, 1'b1, 5'h00);

    // Start held high; operands toggled during SHIFT
    @(negedge clk);
    A = 4'd5; B = 4'd2; Bin = 1'b0; start = 1'b1;
    @(negedge clk);
    n = 0;
    while (!done && n < 20) begin
      A = A ^ 4'hF; B = B ^ 4'h5; Bin = ~Bin;
      n++;
      @(negedge clk);
    end
    chk("held_done", done, 1'b1);
    chk("held_diff", Diff, 4'h3);
    chk("held_bout", Bout, 1'b0);
    A = 4'd7; B = 4'd9; Bin = 1'b1;
    n = 0;
    @(negedge clk);
    n++;
    start = 1'b0;
    chk("b2b_accept_busy", busy, 1'b1);
    chk("b2b_no_done", done, 1'b0);
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("b2b_latency", n, W + 1);
    chk("b2b_diff", Diff, 4'hD);
    chk("b2b_bout", Bout, 1'b1);

    // Reset during the second SHIFT cycle aborts the op
    @(negedge clk);
    A = 4'd9; B = 4'd3; Bin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("abort_busy_pre", busy, 1'b1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_busy", busy, 1'b0);
    chk("abort_done", done, 1'b0);
    chk("abort_diff", Diff, 4'h0);
    chk("abort_bout", Bout, 1'b0);
    n = 0;
    repeat (8) begin
      @(negedge clk);
      if (done) n++;
    end
    chk("abort_no_done", n, 0);
    run_op(4'd12, 4'd5, 1'b1, 5'h06);

    // Random ops with random start gaps
    for (int i = 0; i < 1000; i++) begin
      ra  = W'($urandom);
      rb  = W'($urandom);
      rbi = 1'($urandom);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      run_op(ra, rb, rbi, {1'b0, ra} - {1'b0, rb} - {{W{1'b0}}, rbi});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
